// File: rtl/sram_fifo_controller_pkg.sv
// rtl/sram_fifo_controller_pkg.sv - shared constants for the SRAM FIFO controller
// Purpose : widths and depth of the 16-bit x 256-entry dual-port SRAM FIFO.
// Contents: DATA_W, ADDR_W, DEPTH, COUNT_W (COUNT_W holds 0..DEPTH inclusive).
package sram_fifo_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 256;
  localparam int COUNT_W = 9;
endpackage

// File: rtl/sram_fifo_controller_if.sv
// rtl/sram_fifo_controller_if.sv - dual-port SRAM command/data bus
// Purpose : groups SRAM port A (write) and port B (read) signals.
// Modports: master = FIFO controller (drives commands, receives read data)
//           slave  = SRAM (receives commands, drives Sram_B_Data_In)
interface sram_fifo_controller_if;
  import sram_fifo_pkg::*;

  logic [DATA_W-1:0] Sram_A_Data_Out;
  logic [ADDR_W-1:0] Sram_A_Address_Out;
  logic              Sram_A_Write_Enable_Out;
  logic              Sram_A_Read_Enable_Out;
  logic [ADDR_W-1:0] Sram_B_Address_Out;
  logic              Sram_B_Write_Enable_Out;
  logic              Sram_B_Read_Enable_Out;
  logic [DATA_W-1:0] Sram_B_Data_Out;
  logic [DATA_W-1:0] Sram_B_Data_In;

  modport master (
    output Sram_A_Data_Out, Sram_A_Address_Out, Sram_A_Write_Enable_Out, Sram_A_Read_Enable_Out,
    output Sram_B_Address_Out, Sram_B_Write_Enable_Out, Sram_B_Read_Enable_Out, Sram_B_Data_Out,
    input  Sram_B_Data_In
  );

  modport slave (
    input  Sram_A_Data_Out, Sram_A_Address_Out, Sram_A_Write_Enable_Out, Sram_A_Read_Enable_Out,
    input  Sram_B_Address_Out, Sram_B_Write_Enable_Out, Sram_B_Read_Enable_Out, Sram_B_Data_Out,
    output Sram_B_Data_In
  );
endinterface

// File: rtl/sram_fifo_ptr_ctrl.sv
// rtl/sram_fifo_ptr_ctrl.sv - FIFO pointers, occupancy count and flag decode
// Purpose : tracks write/read pointers and occupancy from accepted push/pop strobes.
// Ports   : i_clk, i_rst_n (async active-low), i_push/i_pop (already-accepted strobes),
//           o_wr_ptr/o_rd_ptr, o_count, o_full/o_empty/o_almost_full/o_almost_empty.
module sram_fifo_ptr_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int ALMOST_FULL_TH  = 240,
  parameter int ALMOST_EMPTY_TH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  output logic [ADDR_W-1:0]  o_wr_ptr,
  output logic [ADDR_W-1:0]  o_rd_ptr,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty
);
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [COUNT_W-1:0] r_count;

  // Pointers wrap naturally at 256 through 8-bit overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_wr_ptr       = r_wr_ptr;
  assign o_rd_ptr       = r_rd_ptr;
  assign o_count        = r_count;
  assign o_full         = (r_count == COUNT_W'(DEPTH));
  assign o_empty        = (r_count == '0);
  assign o_almost_full  = (r_count >= COUNT_W'(ALMOST_FULL_TH));
  assign o_almost_empty = (r_count <= COUNT_W'(ALMOST_EMPTY_TH));
endmodule

// File: rtl/sram_fifo_controller.sv
// rtl/sram_fifo_controller.sv - FIFO controller in front of a 16x256 dual-port SRAM
// Purpose : turns push/pop handshakes into SRAM port A writes and port B reads,
//           registers returned read data, reports occupancy, flags and sticky errors.
// Ports   : Clk_In, Reset_In (async active-low); push Wr_Valid_In/Wr_Data_In/Wr_Ready_Out;
//           pop Rd_En_In/Rd_Data_Out/Rd_Valid_Out; Count_Out and status flags;
//           Overflow_Out/Underflow_Out/Err_Clear_In; Sram_Reset_Out; sram (SRAM bus, master).
// Option  : SRAM_FIFO_ERR_FLAGS_EN enables the sticky overflow/underflow flags;
//           otherwise they read 0 and Err_Clear_In is ignored.
module sram_fifo_controller
  import sram_fifo_pkg::*;
#(
  parameter int ALMOST_FULL_TH  = 240,
  parameter int ALMOST_EMPTY_TH = 16
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Wr_Valid_In,
  input  logic [DATA_W-1:0]     Wr_Data_In,
  output logic                  Wr_Ready_Out,
  input  logic                  Rd_En_In,
  output logic [DATA_W-1:0]     Rd_Data_Out,
  output logic                  Rd_Valid_Out,
  output logic [COUNT_W-1:0]    Count_Out,
  output logic                  Full_Out,
  output logic                  Empty_Out,
  output logic                  Almost_Full_Out,
  output logic                  Almost_Empty_Out,
  output logic                  Overflow_Out,
  output logic                  Underflow_Out,
  input  logic                  Err_Clear_In,
  output logic                  Sram_Reset_Out,
  sram_fifo_controller_if.master sram
);
  logic              w_push_acc;
  logic              w_pop_acc;
  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  sram_fifo_ptr_ctrl #(
    .ALMOST_FULL_TH  (ALMOST_FULL_TH),
    .ALMOST_EMPTY_TH (ALMOST_EMPTY_TH)
  ) u_ptr_ctrl (
    .i_clk          (Clk_In),
    .i_rst_n        (Reset_In),
    .i_push         (w_push_acc),
    .i_pop          (w_pop_acc),
    .o_wr_ptr       (w_wr_ptr),
    .o_rd_ptr       (w_rd_ptr),
    .o_count        (Count_Out),
    .o_full         (Full_Out),
    .o_empty        (Empty_Out),
    .o_almost_full  (Almost_Full_Out),
    .o_almost_empty (Almost_Empty_Out)
  );

  // Reset_In gating keeps ready and both SRAM enables low while reset is held.
  // Full/empty come from registered count, so ready never depends on Rd_En_In.
  assign Wr_Ready_Out = Reset_In & ~Full_Out;
  assign w_push_acc   = Wr_Valid_In & Wr_Ready_Out;
  assign w_pop_acc    = Reset_In & Rd_En_In & ~Empty_Out;

  assign Sram_Reset_Out               = ~Reset_In;
  assign sram.Sram_A_Data_Out         = Wr_Data_In;
  assign sram.Sram_A_Address_Out      = w_wr_ptr;
  assign sram.Sram_A_Write_Enable_Out = w_push_acc;
  assign sram.Sram_A_Read_Enable_Out  = 1'b0;
  assign sram.Sram_B_Address_Out      = w_rd_ptr;
  assign sram.Sram_B_Write_Enable_Out = 1'b0;
  assign sram.Sram_B_Read_Enable_Out  = w_pop_acc;
  assign sram.Sram_B_Data_Out         = '0;

  // The pop-accept strobe is the pending flag: the SRAM drives port B at the
  // negedge of the accept cycle, so the following posedge samples it. Port B
  // data is never sampled outside that cycle.
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop_acc;
      if (w_pop_acc) r_rd_data <= sram.Sram_B_Data_In;
    end
  end

  assign Rd_Data_Out  = r_rd_data;
  assign Rd_Valid_Out = r_rd_valid;

`ifdef SRAM_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Set has priority over clear when both happen in one cycle.
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (Wr_Valid_In && Full_Out) r_overflow <= 1'b1;
      else if (Err_Clear_In)       r_overflow <= 1'b0;
      if (Rd_En_In && Empty_Out)   r_underflow <= 1'b1;
      else if (Err_Clear_In)       r_underflow <= 1'b0;
    end
  end

  assign Overflow_Out  = r_overflow;
  assign Underflow_Out = r_underflow;
`else
  logic w_unused_err_clear;
  assign w_unused_err_clear = Err_Clear_In;
  assign Overflow_Out       = 1'b0;
  assign Underflow_Out      = 1'b0;
`endif
endmodule

// File: tb/tb_sram_fifo_controller.sv
// tb/tb_sram_fifo_controller.sv - self-checking bench for sram_fifo_controller
module tb_sram_fifo_controller;
  localparam int AF_TH = 240;
  localparam int AE_TH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        wr_ready, rd_valid, full, empty, afull, aempty, ovf, udf, sram_rst;
  logic [15:0] rd_data;
  logic [8:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_fifo_controller_if sif();

  sram_fifo_controller #(.ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut (
    .Clk_In           (clk),
    .Reset_In         (rst_n),
    .Wr_Valid_In      (wr_valid),
    .Wr_Data_In       (wr_data),
    .Wr_Ready_Out     (wr_ready),
    .Rd_En_In         (rd_en),
    .Rd_Data_Out      (rd_data),
    .Rd_Valid_Out     (rd_valid),
    .Count_Out        (count),
    .Full_Out         (full),
    .Empty_Out        (empty),
    .Almost_Full_Out  (afull),
    .Almost_Empty_Out (aempty),
    .Overflow_Out     (ovf),
    .Underflow_Out    (udf),
    .Err_Clear_In     (err_clr),
    .Sram_Reset_Out   (sram_rst),
    .sram             (sif)
  );

  // SRAM model: both ports act on the negedge.
  logic [15:0] mem [256];
  always @(negedge clk) begin
    if (sif.Sram_A_Write_Enable_Out) mem[sif.Sram_A_Address_Out] <= sif.Sram_A_Data_Out;
    if (sif.Sram_B_Read_Enable_Out)  sif.Sram_B_Data_In <= mem[sif.Sram_B_Address_Out];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural FIFO model: queue of stored words plus expected registered outputs.
  logic [15:0] m_q[$];
  logic        m_vld = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  int          m_wp = 0;
  int          m_rp = 0;

  always @(posedge clk or negedge rst_n) begin
    bit f, e, pu, po;
    if (!rst_n) begin
      m_q.delete();
      m_vld = 1'b0; m_data = '0; m_ovf = 1'b0; m_udf = 1'b0; m_wp = 0; m_rp = 0;
    end else begin
      f  = (m_q.size() == 256);
      e  = (m_q.size() == 0);
      pu = wr_valid && !f;
      po = rd_en && !e;
      m_vld = po;
      if (po) begin m_data = m_q.pop_front(); m_rp = (m_rp + 1) % 256; end
      if (pu) begin m_q.push_back(wr_data);   m_wp = (m_wp + 1) % 256; end
`ifdef SRAM_FIFO_ERR_FLAGS_EN
      if (wr_valid && f) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (rd_en && e)    m_udf = 1'b1; else if (err_clr) m_udf = 1'b0;
`endif
    end
  end

  // Compare process: mid-cycle, every cycle.
  always @(negedge clk) begin
    int  sz;
    bit  e_full, e_ready, e_push, e_pop;
    sz      = m_q.size();
    e_full  = (sz == 256);
    e_ready = rst_n && !e_full;
    e_push  = wr_valid && e_ready;
    e_pop   = rst_n && rd_en && (sz != 0);
    chk("count",     count,    sz);
    chk("full",      full,     e_full);
    chk("empty",     empty,    sz == 0);
    chk("afull",     afull,    sz >= AF_TH);
    chk("aempty",    aempty,   sz <= AE_TH);
    chk("wr_ready",  wr_ready, e_ready);
    chk("rd_valid",  rd_valid, m_vld);
    chk("rd_data",   rd_data,  m_data);
    chk("overflow",  ovf,      m_ovf);
    chk("underflow", udf,      m_udf);
    chk("sram_rst",  sram_rst, !rst_n);
    chk("a_we",      sif.Sram_A_Write_Enable_Out, e_push);
    chk("b_re",      sif.Sram_B_Read_Enable_Out,  e_pop);
    chk("a_re",      sif.Sram_A_Read_Enable_Out,  0);
    chk("b_we",      sif.Sram_B_Write_Enable_Out, 0);
    chk("b_wdata",   sif.Sram_B_Data_Out,         0);
    if (e_push) begin
      chk("a_addr", sif.Sram_A_Address_Out, m_wp);
      chk("a_data", sif.Sram_A_Data_Out,    wr_data);
    end
    if (e_pop) chk("b_addr", sif.Sram_B_Address_Out, m_rp);
  end

  task automatic step(input logic wv, input logic [15:0] wd, input logic re, input logic clr);
    wr_valid = wv; wr_data = wd; rd_en = re; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  int af_hi = 0, af_lo = 0, ae_hi = 0, ae_lo = 0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty",    empty,    1);
    chk("rst_aempty",   aempty,   1);
    chk("rst_count",    count,    0);
    chk("rst_wr_ready", wr_ready, 0);
    rst_n = 1'b1;
    step(0, 16'h0, 0, 0);

    // Simple ordered push/pop with literal data.
    for (int i = 1; i <= 5; i++) step(1, 16'(i), 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 16'h0, 1, 0);
      chk("t1_valid", rd_valid, 1);
      chk("t1_data",  rd_data,  i);
    end
    chk("t1_empty", empty, 1);

    // Fill to 256, then a refused push.
    for (int i = 0; i < 256; i++) step(1, 16'hA000 + 16'(i), 0, 0);
    chk("t2_full",     full,     1);
    chk("t2_count",    count,    256);
    chk("t2_wr_ready", wr_ready, 0);
    step(1, 16'hDEAD, 0, 0);
    chk("t2_count_hold", count, 256);
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    chk("t2_ovf_set", ovf, 1);
    step(0, 16'h0, 0, 1);
    chk("t2_ovf_clr", ovf, 0);
`endif

    // Full with simultaneous push and pop: pop wins, oldest word returned.
    step(1, 16'h5555, 1, 0);
    chk("t3_data",  rd_data, 16'hA000);
    chk("t3_count", count,   255);
    for (int i = 1; i < 256; i++) begin
      step(0, 16'h0, 1, 0);
      chk("t3_drain", rd_data, 16'hA000 + i);
    end
    chk("t3_empty", empty, 1);
    step(0, 16'h0, 0, 1);

    // Empty with simultaneous push and pop: push wins, no fall-through.
    step(1, 16'hBEEF, 1, 0);
    chk("t4_count", count,    1);
    chk("t4_valid", rd_valid, 0);
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    chk("t4_udf_set", udf, 1);
`endif
    step(0, 16'h0, 1, 1);
    chk("t4_data",  rd_data,  16'hBEEF);
    chk("t4_valid2", rd_valid, 1);
    chk("t4_count2", count,   0);
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    chk("t4_udf_clr", udf, 0);
`endif

    // Randomised streaming: fill-biased, drain-biased, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 700; c++) begin
        logic wv, re;
        wv = (ph == 0) ? ($urandom_range(3) != 0) : (ph == 1) ? ($urandom_range(3) == 0) : $urandom_range(1) == 1;
        re = (ph == 0) ? ($urandom_range(3) == 0) : (ph == 1) ? ($urandom_range(3) != 0) : $urandom_range(1) == 1;
        step(wv, 16'($urandom), re, $urandom_range(15) == 0);
        if (afull)  af_hi++; else af_lo++;
        if (aempty) ae_hi++; else ae_lo++;
      end
    end
    chk("t5_af_high_seen", af_hi > 0, 1);
    chk("t5_af_low_seen",  af_lo > 0, 1);
    chk("t5_ae_high_seen", ae_hi > 0, 1);
    chk("t5_ae_low_seen",  ae_lo > 0, 1);

    // Reset mid-stream with a pop accepted but not yet captured.
    for (int i = 0; i < 10; i++) step(1, 16'h7000 + 16'(i), 0, 0);
    step(0, 16'h0, 1, 0);
    wr_valid = 1'b0; rd_en = 1'b1; err_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid",    rd_valid, 0);
    chk("t6_data",     rd_data,  0);
    chk("t6_count",    count,    0);
    chk("t6_empty",    empty,    1);
    chk("t6_full",     full,     0);
    chk("t6_afull",    afull,    0);
    chk("t6_aempty",   aempty,   1);
    chk("t6_wr_ready", wr_ready, 0);
    chk("t6_b_re",     sif.Sram_B_Read_Enable_Out, 0);
    chk("t6_sram_rst", sram_rst, 1);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_no_pulse", rd_valid, 0);
    rst_n = 1'b1;
    step(0, 16'h0, 1, 0);
    chk("t6_post_valid", rd_valid, 0);
    chk("t6_post_count", count,    0);
    step(0, 16'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_fifo_controller.md
# sram_fifo_controller

Synchronous FIFO controller placed directly upstream of the 16-bit, 256-entry dual-port SRAM. It turns a producer push interface and a consumer pop interface into SRAM port A (write-only) and port B (read-only) commands, and tracks pointers, occupancy and flags. Read data returns from the SRAM's negedge-registered port B output. The controller registers it and presents it to the consumer.

## Interface
Parameters:
- `ALMOST_FULL_TH`, default 240: `Almost_Full_Out` asserts when occupancy is at or above this value (1..256).
- `ALMOST_EMPTY_TH`, default 16: `Almost_Empty_Out` asserts when occupancy is at or below this value (0..255).

Ports:
- `Clk_In`  in  1  single clock. All controller state is on posedge. The SRAM acts on negedge.
- `Reset_In`  in  1  reset, asynchronous, active-low.
- `Wr_Valid_In`  in  1  producer push request.
- `Wr_Data_In`  in  16  push data.
- `Wr_Ready_Out`  out  1  push accepted this cycle when high together with `Wr_Valid_In`. Equals !full.
- `Rd_En_In`  in  1  consumer pop request.
- `Rd_Data_Out`  out  16  popped word.
- `Rd_Valid_Out`  out  1  one-cycle pulse: `Rd_Data_Out` updated.
- `Count_Out`  out  9  occupancy, 0..256.
- `Full_Out`, `Empty_Out`, `Almost_Full_Out`, `Almost_Empty_Out`  out  1 each  status flags.
- `Overflow_Out`, `Underflow_Out`  out  1 each  sticky error flags. Only active with `SRAM_FIFO_ERR_FLAGS_EN`.
- `Err_Clear_In`  in  1  clears the sticky flags.
- `Sram_Reset_Out`  out  1  active-high SRAM reset. Equals !`Reset_In` (combinational).
- `Sram_A_Data_Out` (16), `Sram_A_Address_Out` (8), `Sram_A_Write_Enable_Out` (1), `Sram_A_Read_Enable_Out` (1)  out  SRAM port A.
- `Sram_B_Address_Out` (8), `Sram_B_Write_Enable_Out` (1), `Sram_B_Read_Enable_Out` (1), `Sram_B_Data_Out` (16)  out  SRAM port B.
- `Sram_B_Data_In`  in  16  SRAM port B read data.

## Operation
- Push is accepted when `Wr_Valid_In && !Full_Out`. On accept:
  - Port A is driven combinationally with `Sram_A_Write_Enable_Out`=1, address = `wr_ptr`, data = `Wr_Data_In`.
  - `wr_ptr` increments mod 256 at the next posedge.
- Pop is accepted when `Rd_En_In && !Empty_Out`. On accept:
  - Port B is driven combinationally with `Sram_B_Read_Enable_Out`=1, address = `rd_ptr`.
  - `rd_ptr` increments mod 256 at the next posedge.
- Port A read enable is always 0. Port B write enable and port B write data are always 0. No port ever has both enables high.
- Occupancy:
  - `Count_Out` = count + push_acc − pop_acc.
  - Simultaneous push and pop leaves the count unchanged.
- Flags are decoded from registered state:
  - `Full_Out` = (count==256); `Empty_Out` = (count==0).
  - `Almost_Full_Out` = (count ≥ `ALMOST_FULL_TH`); `Almost_Empty_Out` = (count ≤ `ALMOST_EMPTY_TH`).
- Boundary cases:
  - Full with push and pop in the same cycle: the pop is accepted and the push is refused. Count becomes 255.
  - Empty with push and pop in the same cycle: the push is accepted and the pop is refused. There is no fall-through, so count becomes 1.
  - Both pointers wrap 255→0 with no special handling.
  - A read and a write to the same address never occur in the same cycle.
- Read capture:
  - A pending flag is set on pop accept.
  - At the next posedge the controller captures `Sram_B_Data_In` into `Rd_Data_Out` and pulses `Rd_Valid_Out`.
  - `Rd_Data_Out` holds its value between pops.
  - `Sram_B_Data_In` is never sampled while high-Z, i.e. never outside the pending cycle.
- Reset is asserted asynchronously:
  - Pointers and count clear to 0. `Rd_Data_Out` clears to 0.
  - `Rd_Valid_Out`, `Wr_Ready_Out`, error flags and all SRAM enables clear to 0.
  - `Empty_Out` and `Almost_Empty_Out` go to 1. `Full_Out` and `Almost_Full_Out` go to 0.
  - SRAM contents are not cleared.
  - A pop in flight when reset asserts is discarded.

## Timing
- Push: accepted at posedge k. The SRAM writes at the negedge within cycle k. Count and flags update at posedge k+1.
- Pop latency is 1 cycle: accepted in cycle k, the SRAM reads at the negedge in cycle k, `Rd_Valid_Out`=1 with data at posedge k+1.
- Back-to-back pops give one word per cycle.
- A word pushed at cycle k can be popped from cycle k+1 at the earliest.
- `Wr_Ready_Out` is registered-state derived, with no combinational path from `Rd_En_In`.

## Configuration
- With `SRAM_FIFO_ERR_FLAGS_EN` defined:
  - `Overflow_Out` sets on `Wr_Valid_In && Full_Out`. `Underflow_Out` sets on `Rd_En_In && Empty_Out`.
  - Both flags are sticky and clear on `Err_Clear_In` or reset.
  - If a set event and `Err_Clear_In` occur in the same cycle, set wins.
- Without the macro: both outputs are tied to 0 and `Err_Clear_In` is ignored. The ports remain present.

## Structure
- Package `sram_fifo_pkg` holds the constants DATA_W=16, ADDR_W=8, DEPTH=256, COUNT_W=9.
- One sub-module, `sram_fifo_ptr_ctrl`, contains the pointers, occupancy count and flag decode. The top level holds the SRAM port drive, read capture and error flags.

## Test plan
- Reset, then push 0x0001..0x0005 and pop 5 → `Rd_Data_Out` 0x0001..0x0005, each one cycle after pop. `Empty_Out`=1 at end.
- Push 256 words → `Full_Out`=1, `Count_Out`=256, `Wr_Ready_Out`=0. A further push is not written, and `Overflow_Out`=1 with the macro.
- Full, then push and pop in the same cycle → count 255. The popped word is the oldest. The new word is not stored.
- Empty, then push 0xBEEF and pop in the same cycle → pop refused, count 1. The next cycle's pop returns 0xBEEF.
- Push/pop 300 words streaming → pointers wrap and data order is preserved. `Almost_Full_Out`/`Almost_Empty_Out` toggle at 240/16.
- Assert `Reset_In` low mid-stream, with a pop in flight → all outputs take their reset values immediately and no `Rd_Valid_Out` pulse follows.
